cv32e40p_fetch_buffer_ctrl: RTL

//  Producer side of the IF-stage fetch handshake.

---
 rtl/cv32e40p_fetch_buffer_ctrl_if.sv | 31 +++
 rtl/cv32e40p_fetch_buffer_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cv32e40p_fetch_buffer_ctrl_if.sv
// Signal bundle between the fetch buffer controller, the IF stage and the OBI instruction port.
// The master modport is the controller; the slave modport is its environment.
interface cv32e40p_fetch_buffer_ctrl_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  modport master (
    input  req_i, branch_i, branch_addr_i, fetch_ready_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    output instr_req_o, instr_addr_o, busy_o
  );

  modport slave (
    output req_i, branch_i, branch_addr_i, fetch_ready_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fetch_valid_o, fetch_rdata_o, fetch_addr_o,
    input  instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/cv32e40p_fetch_buffer_ctrl.sv
// IF-stage prefetcher: issues OBI word fetches, buffers responses in a FIFO and
// redirects on branch, dropping every response that belongs to the old stream.
module cv32e40p_fetch_buffer_ctrl #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  cv32e40p_fetch_buffer_ctrl_if.master  bus
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      r_state;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_discard;
  logic [31:0]     r_issue_addr;
  logic [31:0]     r_fetch_addr;
  logic            r_req_hold;
  logic            r_redirect_pend;
  logic [31:0]     r_redirect_addr;

  logic            w_can_issue;
  logic            w_req;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_target;
  logic [OW:0]     w_discard_br;

  assign w_target    = {bus.branch_addr_i[31:2], 2'b00};
  assign w_can_issue = (r_state == ST_RUN) && bus.req_i &&
                       (int'(r_outstanding) < MAX_OUTSTANDING) &&
                       (int'(r_outstanding) + int'(r_count) < DEPTH);
  // An ungranted request must stay up with a stable address until granted.
  assign w_req  = r_req_hold || w_can_issue;
  assign w_gnt  = w_req && bus.instr_gnt_i;
  assign w_rsp  = bus.instr_rvalid_i && (r_outstanding != '0);
  assign w_drop = w_rsp && (r_discard != '0);
  assign w_push = w_rsp && (r_discard == '0) && !bus.branch_i;
  assign w_pop  = (r_count != '0) && bus.fetch_ready_i && !bus.branch_i;

  // Everything in flight, plus the request on the bus this cycle, minus the one returning now.
  assign w_discard_br = {1'b0, r_outstanding} + (OW+1)'(w_req) - (OW+1)'(w_rsp);

  assign bus.instr_req_o   = w_req;
  assign bus.instr_addr_o  = r_issue_addr;
  assign bus.fetch_valid_o = (r_count != '0);
  assign bus.fetch_rdata_o = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign bus.fetch_addr_o  = r_fetch_addr;
  assign bus.busy_o        = (r_outstanding != '0) || w_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_outstanding   <= '0;
      r_discard       <= '0;
      r_issue_addr    <= '0;
      r_fetch_addr    <= '0;
      r_req_hold      <= 1'b0;
      r_redirect_pend <= 1'b0;
      r_redirect_addr <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.branch_i) begin
        r_state <= ST_RUN;
      end
      r_req_hold    <= w_req && !bus.instr_gnt_i;
      r_outstanding <= r_outstanding + OW'(w_gnt) - OW'(w_rsp);

      if (bus.branch_i) begin
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_count      <= '0;
        r_fetch_addr <= w_target;
        r_discard    <= w_discard_br[OW-1:0];
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr       <= r_rptr + AW'(1);
          r_fetch_addr <= r_fetch_addr + 32'd4;
        end
        r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        if (w_drop) begin
          r_discard <= r_discard - OW'(1);
        end
      end

      // A stalled request finishes at its old address; the target is loaded at its grant.
      if (bus.branch_i) begin
        if (w_req && !bus.instr_gnt_i) begin
          r_redirect_pend <= 1'b1;
          r_redirect_addr <= w_target;
        end else begin
          r_redirect_pend <= 1'b0;
          r_issue_addr    <= w_target;
        end
      end else if (w_gnt) begin
        if (r_redirect_pend) begin
          r_redirect_pend <= 1'b0;
          r_issue_addr    <= r_redirect_addr;
        end else begin
          r_issue_addr <= r_issue_addr + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.instr_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (int'(r_count) == DEPTH)));
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(bus.instr_rvalid_i && (r_outstanding == '0)));

endmodule
